// File: rtl/pipeline_pkg.sv
// Shared pipeline types: sequencer state encoding and bundled stage-register enables.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_BOTH = 2'd1,
    WAIT_I    = 2'd2,
    WAIT_D    = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_en_t;

  localparam int NUM_CNT = 3;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)                       count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer: merges cache waits, load-use hazard and EX redirect into stage enables.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_exist,
  input  logic                 br_redirect,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 imem_mask,
  output logic                 dmem_mask,
  output logic                 ibuf_load,
  output logic                 dbuf_load,
  output logic                 ibuf_sel,
  output logic                 dbuf_sel,
  output seq_state_t           state,
  output logic [CNT_WIDTH-1:0] cnt_mem_stall,
  output logic [CNT_WIDTH-1:0] cnt_load_use,
  output logic [CNT_WIDTH-1:0] cnt_redirect
);

  logic       i_done, d_done;
  logic       i_wait, d_wait, stall;
  seq_state_t state_nxt;
  ctrl_en_t   ctrl;

  logic [NUM_CNT-1:0]                inc;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;

  assign i_wait = imem_read & ~imem_resp & ~i_done;
  assign d_wait = dmem_req  & ~dmem_resp & ~d_done;
  assign stall  = i_wait | d_wait;

  always_comb begin
    ctrl      = '0;
    state_nxt = RUN;
    unique case ({i_wait, d_wait})
      2'b11:   state_nxt = WAIT_BOTH;
      2'b10:   state_nxt = WAIT_I;
      2'b01:   state_nxt = WAIT_D;
      default: state_nxt = RUN;
    endcase
    if (!stall) begin
      if (br_redirect) begin
        ctrl = '1;
      end else if (hazard_exist) begin
        ctrl.load_id_ex  = 1'b1;
        ctrl.flush_id_ex = 1'b1;
        ctrl.load_ex_mem = 1'b1;
        ctrl.load_mem_wb = 1'b1;
      end else begin
        ctrl.load_pc     = 1'b1;
        ctrl.load_if_id  = 1'b1;
        ctrl.load_id_ex  = 1'b1;
        ctrl.load_ex_mem = 1'b1;
        ctrl.load_mem_wb = 1'b1;
      end
    end
  end

  // Responses landing during a stall are parked; the flags drop once the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      i_done <= stall & (i_done | imem_resp);
      d_done <= stall & (d_done | dmem_resp);
    end
  end

  assign load_pc     = ctrl.load_pc;
  assign load_if_id  = ctrl.load_if_id;
  assign load_id_ex  = ctrl.load_id_ex;
  assign load_ex_mem = ctrl.load_ex_mem;
  assign load_mem_wb = ctrl.load_mem_wb;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;

  assign imem_mask = stall & i_done;
  assign dmem_mask = stall & d_done;
  assign ibuf_load = stall & imem_resp;
  assign dbuf_load = stall & dmem_resp;
  assign ibuf_sel  = ~stall & i_done;
  assign dbuf_sel  = ~stall & d_done;

  assign inc[0] = stall;
  assign inc[1] = ~stall & ~br_redirect & hazard_exist;
  assign inc[2] = ~stall & br_redirect;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[g]),
      .count(cnt[g])
    );
  end

  assign cnt_mem_stall = cnt[0];
  assign cnt_load_use  = cnt[1];
  assign cnt_redirect  = cnt[2];

endmodule
